// File: rtl/rpm_cmd_sequencer.sv
// Motor rpm command sequencer: manual/auto arbitration, per-frame slew limiting
// toward a clamped target, and a level-sensitive emergency stop.
module rpm_cmd_sequencer #(
   parameter int PERIOD_TICKS = 500000,
   parameter int RPM_MAX      = 10000,
   parameter int RAMP_STEP    = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        estop,
   input  logic        man_req,
   input  logic [15:0] man_rpm,
   input  logic        auto_req,
   input  logic [15:0] auto_rpm,
   output logic        man_gnt,
   output logic        auto_gnt,
   output logic [15:0] rpm_command,
   output logic        frame_tick,
   output logic [1:0]  state,
   output logic        at_target
);

   localparam int CW = $clog2(PERIOD_TICKS + 1);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RAMP = 2'b01;
   localparam logic [1:0] S_HOLD = 2'b10;
   localparam logic [1:0] S_STOP = 2'b11;

   localparam logic [CW-1:0]     CNT_LAST = CW'(PERIOD_TICKS - 1);
   localparam logic [15:0]       MAX_U    = 16'(RPM_MAX);
   localparam logic [15:0]       STEP_U   = 16'(RAMP_STEP);
   localparam logic signed [16:0] STEP_S  = 17'(RAMP_STEP);

   logic [CW-1:0]       cnt, cnt_nxt;
   logic [15:0]         target, tgt_raw, tgt_nxt, step_nxt;
   logic                man_sel, auto_sel;
   logic signed [16:0]  diff;
   logic [1:0]          st_nxt;

   always_comb begin
      cnt_nxt  = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      man_sel  = man_req;
      auto_sel = !man_req && auto_req;
      if (man_sel)
         tgt_raw = man_rpm;
      else if (auto_sel)
         tgt_raw = auto_rpm;
      else
         tgt_raw = '0;
      tgt_nxt = (tgt_raw > MAX_U) ? MAX_U : tgt_raw;

      // 17-bit signed difference keeps the full 0..65535 span without wrap
      diff = $signed({1'b0, tgt_nxt}) - $signed({1'b0, rpm_command});
      if (diff > STEP_S)
         step_nxt = rpm_command + STEP_U;
      else if (diff < -STEP_S)
         step_nxt = rpm_command - STEP_U;
      else
         step_nxt = tgt_nxt;

      st_nxt = state;
      case (state)
         S_IDLE: if (tgt_nxt != '0) st_nxt = S_RAMP;
         S_RAMP: if (step_nxt == tgt_nxt) st_nxt = (tgt_nxt != '0) ? S_HOLD : S_IDLE;
         S_HOLD: if (tgt_nxt != rpm_command) st_nxt = S_RAMP;
         default: st_nxt = state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         frame_tick  <= 1'b0;
         rpm_command <= '0;
         target      <= '0;
         man_gnt     <= 1'b0;
         auto_gnt    <= 1'b0;
         state       <= S_IDLE;
         at_target   <= 1'b1;
      end else begin
         cnt        <= cnt_nxt;
         frame_tick <= (cnt_nxt == CNT_LAST);
         if (estop) begin
            rpm_command <= '0;
            target      <= '0;
            man_gnt     <= 1'b0;
            auto_gnt    <= 1'b0;
            state       <= S_STOP;
            at_target   <= 1'b1;
         end else if (frame_tick) begin
            // Leaving STOP consumes one tick with no grant and no step
            if (state == S_STOP) begin
               state <= S_IDLE;
            end else begin
               man_gnt     <= man_sel;
               auto_gnt    <= auto_sel;
               target      <= tgt_nxt;
               rpm_command <= step_nxt;
               state       <= st_nxt;
               at_target   <= (step_nxt == tgt_nxt);
            end
         end
      end
   end

endmodule

// File: tb/tb_rpm_cmd_sequencer.sv
// Scoreboard bench for rpm_cmd_sequencer: a frame-level reference model pushes
// expected outputs per update edge; a negedge monitor pops and compares.
module tb_rpm_cmd_sequencer;

   localparam int P    = 10;
   localparam int MAXR = 10000;
   localparam int STEP = 100;
   localparam int ST_IDLE = 0, ST_RAMP = 1, ST_HOLD = 2, ST_STOP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        estop = 1'b0;
   logic        man_req = 1'b0;
   logic        auto_req = 1'b0;
   logic [15:0] man_rpm = '0;
   logic [15:0] auto_rpm = '0;
   logic        man_gnt, auto_gnt, frame_tick, at_target;
   logic [15:0] rpm_command;
   logic [1:0]  state;

   rpm_cmd_sequencer #(.PERIOD_TICKS(P), .RPM_MAX(MAXR), .RAMP_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .estop(estop),
      .man_req(man_req), .man_rpm(man_rpm),
      .auto_req(auto_req), .auto_rpm(auto_rpm),
      .man_gnt(man_gnt), .auto_gnt(auto_gnt),
      .rpm_command(rpm_command), .frame_tick(frame_tick),
      .state(state), .at_target(at_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rpm;
      bit mg;
      bit ag;
      int st;
      bit at;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: one update per frame, described in rpm arithmetic
   int m_edges, m_rpm, m_tgt, m_st, m_want, m_prev;
   bit m_mg, m_ag, m_tick;
   exp_t m_e;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_edges = 0; m_rpm = 0; m_tgt = 0; m_st = ST_IDLE; m_mg = 0; m_ag = 0;
            q.delete();
         end else begin
            m_tick = ((m_edges % P) == P - 1);
            m_edges++;
            if (estop || m_tick) begin
               if (estop) begin
                  m_rpm = 0; m_tgt = 0; m_mg = 0; m_ag = 0; m_st = ST_STOP;
               end else if (m_st == ST_STOP) begin
                  m_st = ST_IDLE;
               end else begin
                  m_prev = m_rpm;
                  m_mg = man_req;
                  m_ag = !man_req && auto_req;
                  m_want = m_mg ? int'(man_rpm) : (m_ag ? int'(auto_rpm) : 0);
                  m_tgt = (m_want > MAXR) ? MAXR : m_want;
                  if ((m_tgt - m_rpm <= STEP) && (m_rpm - m_tgt <= STEP))
                     m_rpm = m_tgt;
                  else if (m_tgt > m_rpm)
                     m_rpm = m_rpm + STEP;
                  else
                     m_rpm = m_rpm - STEP;
                  if (m_st == ST_IDLE && m_tgt != 0)
                     m_st = ST_RAMP;
                  else if (m_st == ST_RAMP && m_rpm == m_tgt)
                     m_st = (m_tgt != 0) ? ST_HOLD : ST_IDLE;
                  else if (m_st == ST_HOLD && m_tgt != m_prev)
                     m_st = ST_RAMP;
               end
               m_e.rpm = m_rpm; m_e.mg = m_mg; m_e.ag = m_ag; m_e.st = m_st;
               m_e.at = (m_rpm == m_tgt);
               q.push_back(m_e);
            end
         end
      end
   end

   // Monitor: an update is due after any edge that saw frame_tick or estop
   initial begin
      bit   ev;
      bit   have;
      int   n, last;
      exp_t e;
      ev = 0; have = 0; n = 0; last = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ev = 0; have = 0;
         end else begin
            if (ev) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL scoreboard_underflow: update seen, no expected entry");
               end else begin
                  e = q.pop_front();
                  if (int'(rpm_command) != e.rpm || man_gnt != e.mg || auto_gnt != e.ag ||
                      int'(state) != e.st || at_target != e.at) begin
                     errors++;
                     $display("FAIL scoreboard: got rpm=%0d mg=%0d ag=%0d st=%0d at=%0d, expected rpm=%0d mg=%0d ag=%0d st=%0d at=%0d",
                              rpm_command, man_gnt, auto_gnt, state, at_target,
                              e.rpm, e.mg, e.ag, e.st, e.at);
                  end
               end
            end
            n++;
            if (frame_tick) begin
               if (have) begin
                  checks++;
                  if (n - last != P) begin
                     errors++;
                     $display("FAIL tick_spacing: got %0d cycles, expected %0d", n - last, P);
                  end
               end
               last = n; have = 1;
            end
            ev = frame_tick || estop;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      cyc(n * P);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int found;
      #1_000_000;
      found = 0;
      $display("FAIL watchdog: simulation time limit reached (%0d)", found);
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      cyc(3);
      rst = 1'b0;

      // Reset mid-ramp
      auto_req = 1'b1; auto_rpm = 16'd350;
      frames(3);
      chk("pre_reset_rpm", rpm_command, 300);
      #6;
      rst = 1'b1;
      #1;
      chk("rst_rpm", rpm_command, 0);
      chk("rst_gnt", {man_gnt, auto_gnt}, 0);
      chk("rst_tick", frame_tick, 0);
      chk("rst_state", state, ST_IDLE);
      chk("rst_at_target", at_target, 1);
      cyc(2);
      rst = 1'b0;
      found = 0;
      for (int i = 1; i <= 3 * P; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            found = i;
            break;
         end
      end
      chk("first_tick_cycle", found, P);

      // Ramp up to 350
      cyc(1);
      chk("ramp1_rpm", rpm_command, 100);
      chk("ramp1_state", state, ST_RAMP);
      frames(1); chk("ramp2_rpm", rpm_command, 200);
      frames(1); chk("ramp3_rpm", rpm_command, 300);
      frames(1);
      chk("ramp4_rpm", rpm_command, 350);
      chk("ramp4_state", state, ST_HOLD);
      chk("ramp4_at_target", at_target, 1);

      // Priority and grant hold
      man_req = 1'b1; man_rpm = 16'd2000; auto_rpm = 16'd5000;
      frames(1);
      chk("prio_man_gnt", {man_gnt, auto_gnt}, 2);
      cyc(4);
      man_req = 1'b0;
      cyc(1);
      chk("hold_man_gnt", {man_gnt, auto_gnt}, 2);
      cyc(5);
      chk("switch_auto_gnt", {man_gnt, auto_gnt}, 1);
      chk("switch_rpm", rpm_command, 550);

      // Clamp
      man_req = 1'b1; man_rpm = 16'hFFFF;
      frames(100);
      chk("clamp_rpm", rpm_command, MAXR);
      chk("clamp_state", state, ST_HOLD);

      // Estop from HOLD at 5000
      man_rpm = 16'd5000;
      frames(51);
      chk("pre_estop_rpm", rpm_command, 5000);
      chk("pre_estop_state", state, ST_HOLD);
      cyc(4);
      estop = 1'b1;
      cyc(1);
      chk("estop_rpm", rpm_command, 0);
      chk("estop_state", state, ST_STOP);
      chk("estop_gnt", {man_gnt, auto_gnt}, 0);
      cyc(12);
      chk("estop_held_state", state, ST_STOP);
      estop = 1'b0;
      cyc(3);
      chk("release_state", state, ST_IDLE);
      chk("release_rpm", rpm_command, 0);
      chk("release_gnt", {man_gnt, auto_gnt}, 0);
      frames(1);
      chk("restart_rpm", rpm_command, 100);
      chk("restart_state", state, ST_RAMP);

      // Ramp down to zero
      man_rpm = 16'd250;
      frames(1); chk("up200_rpm", rpm_command, 200);
      frames(1); chk("up250_rpm", rpm_command, 250);
      chk("up250_state", state, ST_HOLD);
      man_req = 1'b0; auto_req = 1'b0;
      frames(1); chk("down150_rpm", rpm_command, 150);
      chk("down150_state", state, ST_RAMP);
      frames(1); chk("down50_rpm", rpm_command, 50);
      frames(1); chk("down0_rpm", rpm_command, 0);
      chk("down0_state", state, ST_IDLE);

      // Estop coinciding with a tick
      auto_req = 1'b1; auto_rpm = 16'd1000;
      frames(3);
      chk("pre_coinc_rpm", rpm_command, 300);
      cyc(9);
      estop = 1'b1;
      chk("coinc_tick_high", frame_tick, 1);
      cyc(1);
      chk("coinc_rpm", rpm_command, 0);
      chk("coinc_state", state, ST_STOP);
      estop = 1'b0;
      frames(2);
      chk("coinc_restart_rpm", rpm_command, 100);

      // Randomized traffic
      for (int it = 0; it < 200; it++) begin
         man_req  = ($urandom_range(0, 2) == 0);
         auto_req = ($urandom_range(0, 2) != 0);
         man_rpm  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12000));
         auto_rpm = 16'($urandom_range(0, 12000));
         estop    = ($urandom_range(0, 19) == 0);
         cyc($urandom_range(1, 25));
      end
      estop = 1'b0;
      frames(2);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
